// File: rtl/serializer_pkg.sv
// Shared state encoding and frame constants for the result serializer.
package serializer_pkg;

    localparam int DATA_W_DEF       = 16;
    localparam int TAG_W_DEF        = 2;
    localparam int CLKS_PER_BIT_DEF = 4;
    localparam int FRAME_BITS       = 1 + TAG_W_DEF + DATA_W_DEF + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        TAG    = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;

endpackage

// File: rtl/result_serializer_bit_timer.sv
// Per-bit timer: ticks bit_end in the last cycle of each serial bit.
module bit_timer
    import serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end = enable && !restart && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !enable || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/result_serializer.sv
// Frames the selected mux result and its op tag as a start/tag/data/
// parity/stop serial word on a single registered tx line.
module result_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int TAG_W        = TAG_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] q_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int SHIFT_W = TAG_W + DATA_W + 1;
    localparam int CNT_MAX = (DATA_W > TAG_W) ? DATA_W : TAG_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TAG_LAST  = CNT_W'(TAG_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 accept;
    logic                 bit_end;

    assign in_ready = (state_q == IDLE);
    assign busy     = ~in_ready;
    assign accept   = in_valid && in_ready;
    assign tx       = tx_q;
    assign done     = (state_q == STOP) && bit_end;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .enable (busy),
        .bit_end(bit_end)
    );

    // shift_q holds {parity, data, tag}; bit 0 is always the next bit out,
    // so tx_d reads bit 1 on the same edge that shifts.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d = {^{tag_in, q_in}, q_in, tag_in};
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    state_d = TAG;
                end
            end
            TAG: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    if (cnt_q == TAG_LAST) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors
// decode tx and compare. DUT 0 runs 4 clocks/bit, DUT 1 runs 1 clock/bit.
module tb_result_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] q_in     [2];
    logic [1:0]  tag_in   [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic        tx       [2];
    logic        busy     [2];
    logic        done     [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          d;
        logic [20:0] f;
    } exp_t;
    exp_t sb[$];

    int start_cyc [2];
    int done_cyc  [2];
    int n_done    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CPB = (g == 0) ? 4 : 1;

        result_serializer #(
            .DATA_W      (16),
            .TAG_W       (2),
            .CLKS_PER_BIT(CPB)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .q_in    (q_in[g]),
            .tag_in  (tag_in[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .tx      (tx[g]),
            .busy    (busy[g]),
            .done    (done[g])
        );

        initial begin : mon
            logic [20:0] got;
            bit          ok;
            bit          abort;
            exp_t        e;
            forever begin
                @(negedge clk);
                if (rst || tx[g]) continue;
                start_cyc[g] = cyc;
                ok    = 1'b1;
                abort = 1'b0;
                got   = '0;
                for (int b = 0; b < 21 && !abort; b++) begin
                    for (int k = 0; k < CPB && !abort; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (rst) begin
                            abort = 1'b1;
                        end else begin
                            if (k == 0) got[b] = tx[g];
                            else if (tx[g] != got[b]) ok = 1'b0;
                            if (in_ready[g] || !busy[g]) ok = 1'b0;
                            if (done[g] != (b == 20 && k == CPB - 1)) ok = 1'b0;
                            if (done[g]) begin
                                done_cyc[g] = cyc;
                                n_done[g]++;
                            end
                        end
                    end
                end
                if (abort) continue;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected dut%0d got %h required none", g, got);
                end else begin
                    e = sb.pop_front();
                    if (e.d != g || e.f != got) begin
                        n_err++;
                        $display("FAIL frame_bits dut%0d got %h required %h (dut%0d)",
                                 g, got, e.f, e.d);
                    end
                end
                n_vec++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL frame_timing dut%0d got unstable/done/ready error required clean", g);
                end
                @(negedge clk);
                n_vec++;
                if (!(tx[g] && in_ready[g] && !done[g] && !busy[g])) begin
                    n_err++;
                    $display("FAIL idle_after dut%0d got tx=%b rdy=%b done=%b required 1 1 0",
                             g, tx[g], in_ready[g], done[g]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic send(input int d, input logic [15:0] q, input logic [1:0] t,
                        input logic p, input bit push, input bit hold,
                        output int acc);
        exp_t e;
        if (push) begin
            e.d = d;
            e.f = {1'b1, p, q, t, 1'b0};
            sb.push_back(e);
        end
        q_in[d]     = q;
        tag_in[d]   = t;
        in_valid[d] = 1'b1;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (in_ready[d]) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout dut%0d got no accept required accept", d);
        end
        @(negedge clk);
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready[d]) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout dut%0d got busy required idle", d);
        end
        @(negedge clk);
    endtask

    int acc, acc2, nd, c0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            q_in[d]      = '0;
            tag_in[d]    = '0;
            n_done[d]    = 0;
            done_cyc[d]  = -1;
            start_cyc[d] = -1;
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_tx", int'(tx[d]), 1);
            check("reset_ready", int'(in_ready[d]), 1);
            check("reset_busy", int'(busy[d]), 0);
            check("reset_done", int'(done[d]), 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic frame, 00FF tag 01, parity 1
        send(0, 16'h00FF, 2'b01, 1'b1, 1, 0, acc);
        wait_idle(0);
        check("t1_start_cyc", start_cyc[0], acc);
        check("t1_done_cyc", done_cyc[0], acc + 83);

        // 2: zero word, parity 0
        nd = n_done[0];
        send(0, 16'h0000, 2'b00, 1'b0, 1, 0, acc);
        wait_idle(0);
        check("t2_done_count", n_done[0] - nd, 1);

        // 3: in_valid while busy is dropped
        nd = n_done[0];
        send(0, 16'hA5A5, 2'b00, 1'b0, 1, 0, acc);
        repeat (10) @(negedge clk);
        q_in[0] = 16'h1234;
        in_valid[0] = 1'b1;
        check("t3_ready_busy", int'(in_ready[0]), 0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_idle(0);
        repeat (100) @(negedge clk);
        check("t3_done_count", n_done[0] - nd, 1);

        // 4: back-to-back with in_valid held
        send(0, 16'h8001, 2'b00, 1'b0, 1, 1, acc);
        send(0, 16'h7FFE, 2'b00, 1'b0, 1, 0, acc2);
        wait_idle(0);
        check("t4_gap", acc2 - acc, 85);
        check("t4_start2", start_cyc[0], acc2);

        // 5: reset in 5th data bit of a zero word
        nd = n_done[0];
        send(0, 16'h0000, 2'b00, 1'b0, 0, 0, acc);
        while (cyc < acc + 29) @(negedge clk);
        check("t5_tx_low", int'(tx[0]), 0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_tx", int'(tx[0]), 1);
        check("t5_rst_ready", int'(in_ready[0]), 1);
        check("t5_rst_done", int'(done[0]), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        check("t5_no_done", n_done[0] - nd, 0);
        c0 = cyc;
        send(0, 16'h0003, 2'b11, 1'b0, 1, 0, acc);
        check("t5_first_accept", acc, c0 + 1);
        wait_idle(0);
        check("t5_done_cyc", done_cyc[0], acc + 83);

        // 6: one clock per bit, FFFF tag 10, parity 1
        send(1, 16'hFFFF, 2'b10, 1'b1, 1, 0, acc);
        wait_idle(1);
        check("t6_start_cyc", start_cyc[1], acc);
        check("t6_done_cyc", done_cyc[1], acc + 20);

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
